// File: rtl/wm_phase_timer.sv
// Washing-machine phase timer: wash/rinse/spin duration FSM with level debouncers.
// Optional macro WM_PAUSE_EN adds a pause input that freezes the phase timer.
module wm_phase_timer #(
    parameter int WASH_CYCLES  = 16,
    parameter int RINSE_CYCLES = 12,
    parameter int SPIN_CYCLES  = 20,
    parameter int FULL_LEVEL   = 200,
    parameter int EMPTY_LEVEL  = 8,
    parameter int DEB_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       door_lock,
    input  logic       soap_wash,
    input  logic       water_wash,
    input  logic       motor_on,
    input  logic       drain_value_on,
`ifdef WM_PAUSE_EN
    input  logic       pause,
`endif
    input  logic [7:0] level,
    output logic       cycle_timeout,
    output logic       spin_timeout,
    output logic       filled,
    output logic       drained,
    output logic [1:0] phase
);

    typedef enum logic [2:0] {S_IDLE, S_WASH, S_RINSE, S_SPIN, S_HOLD} state_t;

    localparam logic [15:0] WASH_D  = WASH_CYCLES[15:0];
    localparam logic [15:0] RINSE_D = RINSE_CYCLES[15:0];
    localparam logic [15:0] SPIN_D  = SPIN_CYCLES[15:0];
    localparam logic [15:0] DEB_D   = DEB_CYCLES[15:0];
    localparam logic [7:0]  FULL_L  = FULL_LEVEL[7:0];
    localparam logic [7:0]  EMPTY_L = EMPTY_LEVEL[7:0];

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n, nxt, dur;
    logic [1:0]  hold_ph, hold_ph_n, req_ph, cur_ph;
    logic        cto_n, sto_n, pause_i;
    logic        spin_req, rinse_req, wash_req;
    logic [15:0] full_cnt, empty_cnt;
    logic        is_full, is_empty;

`ifdef WM_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    // Requests are mutually exclusive, spin taking priority over rinse over wash.
    assign spin_req  = motor_on & drain_value_on;
    assign rinse_req = water_wash & ~spin_req;
    assign wash_req  = soap_wash & ~water_wash & ~spin_req;
    assign req_ph    = spin_req ? 2'd3 : rinse_req ? 2'd2 : wash_req ? 2'd1 : 2'd0;

    always_comb begin
        case (req_ph)
            2'd1:    dur = WASH_D;
            2'd2:    dur = RINSE_D;
            2'd3:    dur = SPIN_D;
            default: dur = 16'd0;
        endcase
        case (state)
            S_WASH:  cur_ph = 2'd1;
            S_RINSE: cur_ph = 2'd2;
            S_SPIN:  cur_ph = 2'd3;
            default: cur_ph = 2'd0;
        endcase
    end

    assign phase = (state == S_HOLD) ? hold_ph : cur_ph;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= 16'd0;
            hold_ph       <= 2'd0;
            cycle_timeout <= 1'b0;
            spin_timeout  <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            hold_ph       <= hold_ph_n;
            cycle_timeout <= cto_n;
            spin_timeout  <= sto_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hold_ph_n = hold_ph;
        cto_n     = cycle_timeout;
        sto_n     = spin_timeout;
        nxt       = 16'd0;
        if (!door_lock) begin
            state_n = S_IDLE;
            cnt_n   = 16'd0;
            cto_n   = 1'b0;
            sto_n   = 1'b0;
        end else if (!pause_i) begin
            case (state)
                S_IDLE, S_WASH, S_RINSE, S_SPIN: begin
                    if (req_ph == 2'd0) begin
                        state_n = S_IDLE;
                        cnt_n   = 16'd0;
                    end else begin
                        // Same request keeps counting; a new request reloads at 1.
                        nxt = (req_ph == cur_ph) ? cnt + 16'd1 : 16'd1;
                        if (nxt >= dur) begin
                            state_n   = S_HOLD;
                            cnt_n     = dur;
                            hold_ph_n = req_ph;
                            if (req_ph == 2'd3) sto_n = 1'b1;
                            else                cto_n = 1'b1;
                        end else begin
                            cnt_n = nxt;
                            case (req_ph)
                                2'd1:    state_n = S_WASH;
                                2'd2:    state_n = S_RINSE;
                                default: state_n = S_SPIN;
                            endcase
                        end
                    end
                end
                S_HOLD: begin
                    if (req_ph != hold_ph) begin
                        state_n = S_IDLE;
                        cnt_n   = 16'd0;
                        cto_n   = 1'b0;
                        sto_n   = 1'b0;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = 16'd0;
                end
            endcase
        end
    end

    assign is_full  = (level >= FULL_L);
    assign is_empty = (level <= EMPTY_L);

    // Each debouncer counts consecutive samples that disagree with its output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_cnt <= 16'd0;
            filled   <= 1'b0;
        end else if (is_full == filled) begin
            full_cnt <= 16'd0;
        end else if (full_cnt + 16'd1 >= DEB_D) begin
            full_cnt <= 16'd0;
            filled   <= is_full;
        end else begin
            full_cnt <= full_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            empty_cnt <= 16'd0;
            drained   <= 1'b1;
        end else if (is_empty == drained) begin
            empty_cnt <= 16'd0;
        end else if (empty_cnt + 16'd1 >= DEB_D) begin
            empty_cnt <= 16'd0;
            drained   <= is_empty;
        end else begin
            empty_cnt <= empty_cnt + 16'd1;
        end
    end

endmodule

// File: doc/wm_phase_timer.md
WM_PHASE_TIMER -- requirements
Module: wm_phase_timer

Interface
REQ-001 The block SHALL provide parameter WASH_CYCLES, default 16, number of clock cycles in the soap-wash phase.
REQ-002 The block SHALL provide parameter RINSE_CYCLES, default 12, number of clock cycles in the water-wash phase.
REQ-003 The block SHALL provide parameter SPIN_CYCLES, default 20, number of clock cycles in the spin phase.
REQ-004 The block SHALL provide parameter FULL_LEVEL, default 200, tank level at or above which water counts as full.
REQ-005 The block SHALL provide parameter EMPTY_LEVEL, default 8, tank level at or below which the tank counts as drained.
REQ-006 The block SHALL provide parameter DEB_CYCLES, default 4, number of consecutive qualifying samples needed to change filled/drained.
REQ-007 Ports SHALL be: clk in 1 system clock; reset in 1 asynchronous active-high reset.
REQ-008 Ports SHALL be: door_lock in 1; soap_wash in 1; water_wash in 1; motor_on in 1; drain_value_on in 1; all are controller status levels.
REQ-009 Ports SHALL be: level in 8 raw tank-level sample, unsigned.
REQ-010 Ports SHALL be: cycle_timeout out 1 wash/rinse phase expired; spin_timeout out 1 spin expired; filled out 1 debounced full; drained out 1 debounced empty.
REQ-011 Ports SHALL be: phase out 2 current state encoding, IDLE=0, WASH=1, RINSE=2, SPIN=3, HOLD reported as the expired phase.

Function
REQ-012 Phase request decode SHALL be: spin_req = motor_on & drain_value_on; rinse_req = water_wash & ~spin_req; wash_req = soap_wash & ~water_wash & ~spin_req.
REQ-013 The FSM SHALL have states IDLE, WASH, RINSE, SPIN, HOLD; from IDLE, a sampled request enters the matching state with count = 1.
REQ-014 In WASH/RINSE/SPIN, count SHALL increment by 1 each cycle while the same request stays high.
REQ-015 When count equals the phase duration, the FSM SHALL enter HOLD; after the N-th consecutive sampled-high edge, the output is registered high.
  - wash/rinse: cycle_timeout
  - spin: spin_timeout
REQ-016 In HOLD, the timeout output SHALL stay high until its request drops; the FSM then returns to IDLE and clears the timeout on that same edge.
REQ-017 A change to a different request mid-phase SHALL reload count = 1 in the new state with no timeout.
REQ-018 All requests low mid-phase SHALL return the FSM to IDLE with no timeout.
REQ-019 door_lock sampled low SHALL force IDLE, clear count and both timeouts, and ignore requests; it overrides REQ-013..018.
REQ-020 Count width SHALL be 16 bits unsigned; durations of 0 are illegal; count SHALL never wrap, because it saturates at the duration.
REQ-021 filled SHALL set after DEB_CYCLES consecutive samples with level >= FULL_LEVEL, and clear after DEB_CYCLES consecutive samples with level < FULL_LEVEL.
REQ-022 drained SHALL behave as in REQ-021 using level <= EMPTY_LEVEL; a broken run SHALL restart the debounce counter from 0.
REQ-023 Both debouncers SHALL run regardless of FSM state and door_lock.

Reset
REQ-024 When reset is high, the block SHALL asynchronously force: FSM = IDLE, count = 0, phase = 0, cycle_timeout = 0, spin_timeout = 0, filled = 0, drained = 1, debounce counters = 0.
REQ-025 Reset asserted mid-phase SHALL abort the phase; after release, the next request SHALL start a fresh count at 1.

Configuration
REQ-026 With WM_PAUSE_EN defined, the block SHALL add an input port pause (1 bit); while pause is high, count holds and no state transitions occur except door_lock/reset aborts.
REQ-027 Without WM_PAUSE_EN, the pause port SHALL NOT exist and count SHALL advance every cycle as specified.

Verification
REQ-028 door_lock=1 and soap_wash held high from edge 0 (WASH_CYCLES=16) -> cycle_timeout=0 through edge 15, 1 after edge 16, and held until soap_wash drops.
REQ-029 door_lock=1, motor_on=1, drain_value_on=1 for 20 edges -> spin_timeout high after edge 20, phase=3; then drop drain_value_on -> spin_timeout=0, phase=0 on the next edge.
REQ-030 soap_wash high for 10 edges, then water_wash high -> RINSE entered with count=1, no cycle_timeout, and cycle_timeout rises 12 edges later.
REQ-031 door_lock dropped at count=7 of WASH -> IDLE and timeouts 0 on the next edge; restoring door_lock restarts the count at 1.
REQ-032 level=210 for 3 samples, then 150, then 210 for 4 samples -> filled rises only after the 4th consecutive sample; reset mid-run -> filled=0, drained=1 immediately.
REQ-033 With WM_PAUSE_EN: pause high for 5 cycles at count=8 of WASH -> timeout delayed by exactly 5 cycles.
